// File: rtl/hazard_ctrl.sv
// hazard_ctrl: central hazard unit for the 5-stage pipeline.
// Tracks per-stage destination/result-class shadows for E, M and W.
// From those shadows it derives the stall request, the forwarding-mux
// selects and the HI/LO multiply/divide busy interlock.
module hazard_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       EXC_flush,
  input  logic [4:0] A1_D,
  input  logic [4:0] A2_D,
  input  logic [4:0] A3_D,
  input  logic [1:0] Res_D,
  input  logic [1:0] Tuse_rs_D,
  input  logic [1:0] Tuse_rt_D,
  input  logic       md_start_D,
  input  logic       md_div_D,
  input  logic       md_use_D,
  output logic       stall,
  output logic [1:0] fwd_rs_D,
  output logic [1:0] fwd_rt_D,
  output logic [1:0] fwd_rs_E,
  output logic [1:0] fwd_rt_E,
  output logic       fwd_rt_M,
  output logic       md_busy
);

  localparam logic [1:0] RES_NW  = 2'b00;
  localparam logic [1:0] RES_ALU = 2'b01;
  localparam logic [1:0] RES_DM  = 2'b10;
  localparam logic [1:0] RES_PC  = 2'b11;
  localparam logic [1:0] TUSE_NONE = 2'b11;

  // E keeps both source addresses for E-stage forwarding; M keeps rt for
  // store-data forwarding. W's rt is never consulted, so W keeps Res and A3.
  logic [1:0] res_e_r, res_m_r, res_w_r;
  logic [4:0] a1_e_r, a2_e_r, a3_e_r;
  logic [4:0] a2_m_r, a3_m_r;
  logic [4:0] a3_w_r;
  logic [CNT_W-1:0] md_cnt_r;

  logic stall_rs_s, stall_rt_s, stall_md_s, stall_s;
  logic md_load_s;
  logic [CNT_W-1:0] md_cnt_nxt_s;
  logic [1:0] fwd_rs_d_s, fwd_rt_d_s, fwd_rs_e_s, fwd_rt_e_s;
  logic fwd_rt_m_s;

  // Cycles until an E-stage instruction has its result available.
  function automatic logic [1:0] tnew_e_f(input logic [1:0] res);
    case (res)
      RES_ALU: tnew_e_f = 2'd1;
      RES_DM:  tnew_e_f = 2'd2;
      default: tnew_e_f = 2'd0;
    endcase
  endfunction

  // Cycles until an M-stage instruction has its result available.
  function automatic logic [1:0] tnew_m_f(input logic [1:0] res);
    case (res)
      RES_DM:  tnew_m_f = 2'd1;
      default: tnew_m_f = 2'd0;
    endcase
  endfunction

  // True when a D source would be read before its producer in E or M is ready.
  function automatic logic data_hazard_f(
    input logic [4:0] addr, input logic [1:0] tuse,
    input logic [1:0] res_e, input logic [4:0] a3_e,
    input logic [1:0] res_m, input logic [4:0] a3_m
  );
    logic hit_e, hit_m;
    hit_e = (res_e != RES_NW) && (a3_e == addr) && (tuse < tnew_e_f(res_e));
    hit_m = (res_m != RES_NW) && (a3_m == addr) && (tuse < tnew_m_f(res_m));
    data_hazard_f = (addr != 5'd0) && (tuse != TUSE_NONE) && (hit_e || hit_m);
  endfunction

  // D-stage bypass select: youngest ready producer wins.
  function automatic logic [1:0] fwd_d_f(
    input logic [4:0] addr,
    input logic [1:0] res_e, input logic [4:0] a3_e,
    input logic [1:0] res_m, input logic [4:0] a3_m,
    input logic [1:0] res_w, input logic [4:0] a3_w
  );
    if (addr == 5'd0) begin
      fwd_d_f = 2'b00;
    end else if ((res_e == RES_PC) && (a3_e == addr)) begin
      fwd_d_f = 2'b01;
    end else if (((res_m == RES_ALU) || (res_m == RES_PC)) && (a3_m == addr)) begin
      fwd_d_f = 2'b10;
    end else if ((res_w != RES_NW) && (a3_w == addr)) begin
      fwd_d_f = 2'b11;
    end else begin
      fwd_d_f = 2'b00;
    end
  endfunction

  // E-stage bypass select: M result if ready, otherwise W.
  function automatic logic [1:0] fwd_e_f(
    input logic [4:0] addr,
    input logic [1:0] res_m, input logic [4:0] a3_m,
    input logic [1:0] res_w, input logic [4:0] a3_w
  );
    if (addr == 5'd0) begin
      fwd_e_f = 2'b00;
    end else if (((res_m == RES_ALU) || (res_m == RES_PC)) && (a3_m == addr)) begin
      fwd_e_f = 2'b01;
    end else if ((res_w != RES_NW) && (a3_w == addr)) begin
      fwd_e_f = 2'b10;
    end else begin
      fwd_e_f = 2'b00;
    end
  endfunction

  // Stall decision; a flush squashes everything behind it, so never stall then.
  always_comb begin
    stall_rs_s = data_hazard_f(A1_D, Tuse_rs_D, res_e_r, a3_e_r, res_m_r, a3_m_r);
    stall_rt_s = data_hazard_f(A2_D, Tuse_rt_D, res_e_r, a3_e_r, res_m_r, a3_m_r);
    stall_md_s = md_use_D && (md_cnt_r != {CNT_W{1'b0}});
    if (EXC_flush) begin
      stall_s = 1'b0;
    end else begin
      stall_s = stall_rs_s || stall_rt_s || stall_md_s;
    end
  end

  // Forwarding selects for D, E and M consumers.
  always_comb begin
    fwd_rs_d_s = fwd_d_f(A1_D, res_e_r, a3_e_r, res_m_r, a3_m_r, res_w_r, a3_w_r);
    fwd_rt_d_s = fwd_d_f(A2_D, res_e_r, a3_e_r, res_m_r, a3_m_r, res_w_r, a3_w_r);
    fwd_rs_e_s = fwd_e_f(a1_e_r, res_m_r, a3_m_r, res_w_r, a3_w_r);
    fwd_rt_e_s = fwd_e_f(a2_e_r, res_m_r, a3_m_r, res_w_r, a3_w_r);
    fwd_rt_m_s = (a2_m_r != 5'd0) && (a2_m_r == a3_w_r) && (res_w_r != RES_NW);
  end

  // Busy-counter next value: a start that issues reloads, otherwise count down to 0.
  always_comb begin
    md_load_s = md_start_D && !stall_s && !EXC_flush;
    if (md_load_s) begin
      md_cnt_nxt_s = md_div_D ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
    end else if (md_cnt_r != {CNT_W{1'b0}}) begin
      md_cnt_nxt_s = md_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      md_cnt_nxt_s = {CNT_W{1'b0}};
    end
  end

  // Pipeline shadow advance: flush empties E/M/W, stall bubbles E only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_e_r <= 2'b00; a1_e_r <= 5'd0; a2_e_r <= 5'd0; a3_e_r <= 5'd0;
      res_m_r <= 2'b00; a2_m_r <= 5'd0; a3_m_r <= 5'd0;
      res_w_r <= 2'b00; a3_w_r <= 5'd0;
    end else if (EXC_flush) begin
      res_e_r <= 2'b00; a1_e_r <= 5'd0; a2_e_r <= 5'd0; a3_e_r <= 5'd0;
      res_m_r <= 2'b00; a2_m_r <= 5'd0; a3_m_r <= 5'd0;
      res_w_r <= 2'b00; a3_w_r <= 5'd0;
    end else begin
      if (stall_s) begin
        res_e_r <= 2'b00; a1_e_r <= 5'd0; a2_e_r <= 5'd0; a3_e_r <= 5'd0;
      end else begin
        res_e_r <= Res_D; a1_e_r <= A1_D; a2_e_r <= A2_D; a3_e_r <= A3_D;
      end
      res_m_r <= res_e_r; a2_m_r <= a2_e_r; a3_m_r <= a3_e_r;
      res_w_r <= res_m_r; a3_w_r <= a3_m_r;
    end
  end

  // HI/LO busy counter; a flush does not abort an in-flight operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt_r <= {CNT_W{1'b0}};
    end else begin
      md_cnt_r <= md_cnt_nxt_s;
    end
  end

  assign stall    = stall_s;
  assign fwd_rs_D = fwd_rs_d_s;
  assign fwd_rt_D = fwd_rt_d_s;
  assign fwd_rs_E = fwd_rs_e_s;
  assign fwd_rt_E = fwd_rt_e_s;
  assign fwd_rt_M = fwd_rt_m_s;
  assign md_busy  = (md_cnt_r != {CNT_W{1'b0}});

endmodule
